// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM that walks the single-bus CPU through
// fetch / decode / execute. It drives the PC clear/increment/output-enable
// lines, shares the address bus between the PC and the operand field,
// handshakes with memory through FS_mem_ready and counts retired
// instructions with a saturating counter.
//
// Optional feature: define FS_WAIT_TIMEOUT_EN to bound every memory wait to
// TIMEOUT cycles. A timeout sends the FSM to HALT with a sticky FS_fault. In
// the default build waits are unbounded and FS_fault is tied low.
module fetch_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             FS_clock,
    input  logic             FS_reset,
    input  logic             FS_run,
    input  logic             FS_mem_ready,
    input  logic [3:0]       FS_opcode,
    output logic             FS_pc_reset,
    output logic             FS_pc_increment,
    output logic             FS_pc_output_en,
    output logic             FS_opr_output_en,
    output logic             FS_mem_read,
    output logic             FS_mem_write,
    output logic             FS_ir_load,
    output logic             FS_acc_load,
    output logic             FS_halted,
    output logic             FS_fault,
    output logic [2:0]       FS_state,
    output logic [CNT_W-1:0] FS_retired
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_FETCH   = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC_RD = 3'd4,
        S_EXEC_WR = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [3:0]       OP_LOAD  = 4'h1;
    localparam logic [3:0]       OP_STORE = 4'h2;
    localparam logic [3:0]       OP_HLT   = 4'hF;
    localparam logic [CNT_W-1:0] RET_MAX  = '1;

    state_t           state;
    state_t           after_retire;
    logic [CNT_W-1:0] retired;
    logic             in_wait;
    logic             timeout_hit;
    logic             retire;

    // A zero or negative wait budget would make every bus phase time out at once.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT must be at least 1");
    end

    // States in which the FSM is waiting for memory to answer.
    assign in_wait = (state == S_FETCH) || (state == S_EXEC_RD) || (state == S_EXEC_WR);

    // Where to go once an instruction retires; FS_run is only looked at here and in IDLE.
    assign after_retire = FS_run ? S_FETCH : S_IDLE;

`ifdef FS_WAIT_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] wait_cnt;
    logic          fault;

    // The counter sits at zero outside a bus phase, so every phase entry starts clean.
    assign timeout_hit = in_wait && (wait_cnt == WAIT_LIMIT);

    // Wait-cycle counter and sticky fault flag.
    always_ff @(posedge FS_clock or posedge FS_reset) begin
        if (FS_reset) begin
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            if (!in_wait || FS_mem_ready || timeout_hit) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (timeout_hit) begin
                fault <= 1'b1;
            end
        end
    end

    assign FS_fault = fault;
`else
    assign timeout_hit = 1'b0;
    assign FS_fault    = 1'b0;
`endif

    // An instruction retires in DECODE (NOP and HLT) or when its execute phase completes.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE:             retire = (FS_opcode != OP_LOAD) && (FS_opcode != OP_STORE);
            S_EXEC_RD, S_EXEC_WR: retire = FS_mem_ready && !timeout_hit;
            default:              retire = 1'b0;
        endcase
    end

    // State sequencing and saturating retired-instruction count.
    always_ff @(posedge FS_clock or posedge FS_reset) begin
        if (FS_reset) begin
            state   <= S_INIT;
            retired <= '0;
        end else begin
            if (retire && (retired != RET_MAX)) begin
                retired <= retired + CNT_W'(1);
            end
            if (timeout_hit) begin
                state <= S_HALT;
            end else begin
                case (state)
                    S_INIT: state <= S_IDLE;
                    S_IDLE: begin
                        if (FS_run) begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (FS_mem_ready) begin
                            state <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        case (FS_opcode)
                            OP_LOAD:  state <= S_EXEC_RD;
                            OP_STORE: state <= S_EXEC_WR;
                            OP_HLT:   state <= S_HALT;
                            default:  state <= after_retire;
                        endcase
                    end
                    S_EXEC_RD, S_EXEC_WR: begin
                        if (FS_mem_ready) begin
                            state <= after_retire;
                        end
                    end
                    S_HALT:  state <= S_HALT;
                    default: state <= S_INIT;
                endcase
            end
        end
    end

    // Strobes decode from the state register; ready-qualified pulses follow memory directly.
    // Reset forces INIT asynchronously, and the PC clear is held off until reset is released.
    always_comb begin
        FS_pc_reset      = 1'b0;
        FS_pc_increment  = 1'b0;
        FS_pc_output_en  = 1'b0;
        FS_opr_output_en = 1'b0;
        FS_mem_read      = 1'b0;
        FS_mem_write     = 1'b0;
        FS_ir_load       = 1'b0;
        FS_acc_load      = 1'b0;
        FS_halted        = 1'b0;
        case (state)
            S_INIT: FS_pc_reset = !FS_reset;
            S_FETCH: begin
                if (!timeout_hit) begin
                    FS_pc_output_en = 1'b1;
                    FS_mem_read     = 1'b1;
                    FS_ir_load      = FS_mem_ready;
                    FS_pc_increment = FS_mem_ready;
                end
            end
            S_EXEC_RD: begin
                if (!timeout_hit) begin
                    FS_opr_output_en = 1'b1;
                    FS_mem_read      = 1'b1;
                    FS_acc_load      = FS_mem_ready;
                end
            end
            S_EXEC_WR: begin
                if (!timeout_hit) begin
                    FS_opr_output_en = 1'b1;
                    FS_mem_write     = 1'b1;
                end
            end
            S_HALT:  FS_halted = 1'b1;
            default: ;
        endcase
    end

    assign FS_state   = state;
    assign FS_retired = retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized programs
// checked cycle by cycle against an instruction-level timeline model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int CNT_W = 3;
    localparam int RET_SAT = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic             mem_ready = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic             pc_reset;
    logic             pc_increment;
    logic             pc_output_en;
    logic             opr_output_en;
    logic             mem_read;
    logic             mem_write;
    logic             ir_load;
    logic             acc_load;
    logic             halted;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.CNT_W(CNT_W), .TIMEOUT(255)) dut (
        .FS_clock(clock),
        .FS_reset(reset),
        .FS_run(run),
        .FS_mem_ready(mem_ready),
        .FS_opcode(opcode),
        .FS_pc_reset(pc_reset),
        .FS_pc_increment(pc_increment),
        .FS_pc_output_en(pc_output_en),
        .FS_opr_output_en(opr_output_en),
        .FS_mem_read(mem_read),
        .FS_mem_write(mem_write),
        .FS_ir_load(ir_load),
        .FS_acc_load(acc_load),
        .FS_halted(halted),
        .FS_fault(fault),
        .FS_state(state),
        .FS_retired(retired)
    );

    always #5 clock = ~clock;

    // {pc_reset, pc_inc, pc_oe, opr_oe, rd, wr, ir, acc, halted, fault}
    function automatic logic [9:0] observed_strobes();
        return {pc_reset, pc_increment, pc_output_en, opr_output_en, mem_read,
                mem_write, ir_load, acc_load, halted, fault};
    endfunction

    // One expected clock cycle of the timeline model.
    typedef struct {
        logic        run;
        logic        ready;
        logic [3:0]  op;
        logic [2:0]  st;
        logic [9:0]  strobes;
        int          ret;
    } cyc_t;

    cyc_t trace[$];
    int   model_ret;

    task automatic add_cycle(input logic run_i, input logic ready_i, input logic [3:0] op_i,
                             input logic [2:0] st_i, input logic poe, input logic ooe,
                             input logic rd, input logic wr, input logic ir,
                             input logic inc, input logic acc);
        cyc_t e;
        e.run     = run_i;
        e.ready   = ready_i;
        e.op      = op_i;
        e.st      = st_i;
        e.strobes = {st_i == 3'd0, inc, poe, ooe, rd, wr, ir, acc, st_i == 3'd6, 1'b0};
        e.ret     = model_ret;
        trace.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic count_retire();
        if (model_ret < RET_SAT) model_ret++;
    endtask

    // Expand a random program into its expected cycle-by-cycle timeline:
    // fetch = waits + 1, NOP/HLT decode = 1, LOAD/STORE adds waits + 1 execute cycles.
    task automatic build_program(input int n_instr, input bit end_halt);
        logic [3:0] op;
        int         wf, we, k;
        logic       keep_running;
        bit         last;
        trace.delete();
        model_ret = 0;
        add_cycle(1'b0, rbit(), rop(), 3'd0, 0, 0, 0, 0, 0, 0, 0);
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) add_cycle(1'b0, rbit(), rop(), 3'd1, 0, 0, 0, 0, 0, 0, 0);
        add_cycle(1'b1, rbit(), rop(), 3'd1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n_instr; i++) begin
            last = (i == n_instr - 1);
            case ($urandom_range(0, 3))
                0: op = 4'h1;
                1: op = 4'h2;
                default: begin
                    do op = rop(); while (op == 4'h1 || op == 4'h2 || op == 4'hF);
                end
            endcase
            if (last && end_halt) op = 4'hF;
            wf = $urandom_range(0, 3);
            we = $urandom_range(0, 3);
            keep_running = last ? 1'b0 : ($urandom_range(0, 3) != 0);
            for (int w = 0; w < wf; w++) add_cycle(rbit(), 1'b0, op, 3'd2, 1, 0, 1, 0, 0, 0, 0);
            add_cycle(rbit(), 1'b1, op, 3'd2, 1, 0, 1, 0, 1, 1, 0);
            if (op == 4'h1 || op == 4'h2) begin
                add_cycle(rbit(), rbit(), op, 3'd3, 0, 0, 0, 0, 0, 0, 0);
                for (int w = 0; w < we; w++)
                    add_cycle(rbit(), 1'b0, rop(), (op == 4'h1) ? 3'd4 : 3'd5, 0, 1,
                              op == 4'h1, op == 4'h2, 0, 0, 0);
                add_cycle(keep_running, 1'b1, rop(), (op == 4'h1) ? 3'd4 : 3'd5, 0, 1,
                          op == 4'h1, op == 4'h2, 0, 0, op == 4'h1);
                count_retire();
            end else if (op == 4'hF) begin
                add_cycle(rbit(), rbit(), op, 3'd3, 0, 0, 0, 0, 0, 0, 0);
                count_retire();
                for (int h = 0; h < 4; h++) add_cycle(rbit(), rbit(), rop(), 3'd6, 0, 0, 0, 0, 0, 0, 0);
                break;
            end else begin
                add_cycle(keep_running, rbit(), op, 3'd3, 0, 0, 0, 0, 0, 0, 0);
                count_retire();
            end
            if (!keep_running) begin
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) add_cycle(1'b0, rbit(), rop(), 3'd1, 0, 0, 0, 0, 0, 0, 0);
                add_cycle(!last, rbit(), rop(), 3'd1, 0, 0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 4'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = 4'h1;
        @(negedge clock); #1;
        checks++;
        if (state !== 3'd0 || observed_strobes() !== 10'd0 || retired !== '0) begin
            errors++;
            $display("FAIL reset_held: state=%0d strobes=%b retired=%0d, required state=0 strobes=0 retired=0",
                     state, observed_strobes(), retired);
        end
        @(negedge clock);
        reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || observed_strobes() !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_init: state=%0d strobes=%b, required state=0 strobes=1000000000",
                     state, observed_strobes());
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            mem_ready = rbit(); opcode = rop();
            #1;
            checks++;
            if (state !== 3'd1 || observed_strobes() !== 10'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: state=%0d strobes=%b, required state=1 strobes=0",
                         c, state, observed_strobes());
            end
        end
    endtask

    task automatic test_nop_burst();
        int incs = 0;
        int last = -1;
        bit placed = 1'b1;
        bit clash = 1'b0;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clock);
            run = (c >= 1 && c <= 6);
            mem_ready = 1'b1;
            opcode = 4'h7;
            #1;
            if (pc_increment) begin
                if ((last < 0 && c != 2) || (last >= 0 && c - last != 2)) placed = 1'b0;
                last = c;
                incs++;
            end
            if (pc_output_en && opr_output_en) clash = 1'b1;
        end
        checks++;
        if (incs != 3 || !placed) begin
            errors++;
            $display("FAIL nop_increments: pulses=%0d well_spaced=%0d, required pulses=3 at cycles 2,4,6", incs, placed);
        end
        checks++;
        if (retired !== CNT_W'(3) || state !== 3'd1) begin
            errors++;
            $display("FAIL nop_retired: retired=%0d state=%0d, required retired=3 state=1", retired, state);
        end
        checks++;
        if (clash) begin
            errors++;
            $display("FAIL nop_bus_exclusive: both bus enables seen high, required never");
        end
    endtask

    task automatic test_load_wait();
        int opr_cycles = 0;
        int acc_pulses = 0;
        int exec_incs = 0;
        apply_reset();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clock);
            run = (c >= 1 && c <= 7);
            mem_ready = (c == 2 || c == 8);
            opcode = 4'h1;
            #1;
            if (opr_output_en) opr_cycles++;
            if (acc_load) acc_pulses++;
            if (c >= 3 && c <= 8 && pc_increment) exec_incs++;
        end
        checks++;
        if (opr_cycles != 5) begin
            errors++;
            $display("FAIL load_opr_en: cycles=%0d, required 5", opr_cycles);
        end
        checks++;
        if (acc_pulses != 1) begin
            errors++;
            $display("FAIL load_acc_load: pulses=%0d, required 1", acc_pulses);
        end
        checks++;
        if (exec_incs != 0) begin
            errors++;
            $display("FAIL load_no_increment: pulses=%0d, required 0", exec_incs);
        end
        checks++;
        if (retired !== CNT_W'(1) || state !== 3'd1) begin
            errors++;
            $display("FAIL load_retired: retired=%0d state=%0d, required retired=1 state=1", retired, state);
        end
    endtask

    task automatic test_store_halt();
        int wr_cycles = 0;
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clock);
            run = (c >= 7) ? rbit() : (c >= 1);
            mem_ready = 1'b1;
            opcode = (c <= 4) ? 4'h2 : 4'hF;
            #1;
            if (mem_write) wr_cycles++;
            if (c >= 7) begin
                checks++;
                if (state !== 3'd6 || observed_strobes() !== 10'b00_0000_0010 || retired !== CNT_W'(2)) begin
                    errors++;
                    $display("FAIL halt_hold cycle %0d: state=%0d strobes=%b retired=%0d, required state=6 strobes=0000000010 retired=2",
                             c, state, observed_strobes(), retired);
                end
            end
        end
        checks++;
        if (wr_cycles != 1) begin
            errors++;
            $display("FAIL store_write_phase: write cycles=%0d, required 1", wr_cycles);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit_reset: state=%0d halted=%0d, required state=0 halted=0", state, halted);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_run_drop();
        int incs = 0;
        apply_reset();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clock);
            run = (c >= 1 && c <= 2);
            mem_ready = (c == 6);
            opcode = 4'h5;
            #1;
            if (pc_increment) incs++;
            if (c == 8 || c == 10) begin
                checks++;
                if (state !== 3'd1 || retired !== CNT_W'(1)) begin
                    errors++;
                    $display("FAIL run_drop cycle %0d: state=%0d retired=%0d, required state=1 retired=1",
                             c, state, retired);
                end
            end
        end
        checks++;
        if (incs != 1) begin
            errors++;
            $display("FAIL run_drop_increments: pulses=%0d, required 1", incs);
        end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clock);
            run = (c >= 1);
            mem_ready = (c == 2 || c == 4);
            opcode = (c <= 3) ? 4'h0 : 4'h2;
            #1;
        end
        checks++;
        if (state !== 3'd5 || mem_write !== 1'b1 || opr_output_en !== 1'b1 || retired !== CNT_W'(1)) begin
            errors++;
            $display("FAIL write_wait: state=%0d wr=%0d opr_oe=%0d retired=%0d, required state=5 wr=1 opr_oe=1 retired=1",
                     state, mem_write, opr_output_en, retired);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || observed_strobes() !== 10'd0 || retired !== '0) begin
            errors++;
            $display("FAIL async_reset: state=%0d strobes=%b retired=%0d, required state=0 strobes=0 retired=0",
                     state, observed_strobes(), retired);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random_program(input int n_instr, input bit end_halt);
        build_program(n_instr, end_halt);
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < trace.size(); c++) begin
            if (c > 0) @(negedge clock);
            run = trace[c].run;
            mem_ready = trace[c].ready;
            opcode = trace[c].op;
            #1;
            checks++;
            if (state !== trace[c].st) begin
                errors++;
                $display("FAIL rand_state cycle %0d: got %0d, required %0d", c, state, trace[c].st);
            end
            checks++;
            if (observed_strobes() !== trace[c].strobes) begin
                errors++;
                $display("FAIL rand_strobes cycle %0d: got %b, required %b", c, observed_strobes(), trace[c].strobes);
            end
            checks++;
            if (retired !== CNT_W'(trace[c].ret)) begin
                errors++;
                $display("FAIL rand_retired cycle %0d: got %0d, required %0d", c, retired, trace[c].ret);
            end
            checks++;
            if ((pc_output_en && opr_output_en) || (mem_read && mem_write)) begin
                errors++;
                $display("FAIL rand_exclusive cycle %0d: pc_oe=%0d opr_oe=%0d rd=%0d wr=%0d, required no pair both high",
                         c, pc_output_en, opr_output_en, mem_read, mem_write);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop_burst();
        test_load_wait();
        test_store_halt();
        test_run_drop();
        test_reset_mid_write();
        test_random_program(30, 1'b1);
        test_random_program(30, 1'b0);
        test_random_program(25, 1'b1);
        test_random_program(40, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the program counter through fetch/decode/execute for the single-bus CPU.
- Drives the PC's sync reset, increment and tri-state output enable.
- Shares the address bus between the PC and the operand field, and handshakes with memory via a ready signal.
- Sits between the instruction register/decoder and the PC, memory and accumulator control lines.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT, 255, maximum wait cycles on FS_mem_ready (used only with the optional feature).

Ports:
- FS_clock  input  1  system clock, rising edge.
- FS_reset  input  1  asynchronous, active-high reset.
- FS_run  input  1  level; 1 = execute continuously, 0 = stop at the next instruction boundary.
- FS_mem_ready  input  1  memory completes the current read/write in this cycle.
- FS_opcode  input  4  upper nibble of the instruction register, valid from the DECODE state.
- FS_pc_reset  output  1  synchronous clear to the PC.
- FS_pc_increment  output  1  one-cycle PC increment pulse.
- FS_pc_output_en  output  1  PC drives the address bus.
- FS_opr_output_en  output  1  operand field drives the address bus.
- FS_mem_read  output  1  memory read request.
- FS_mem_write  output  1  memory write request.
- FS_ir_load  output  1  IR captures the data bus.
- FS_acc_load  output  1  accumulator captures the data bus.
- FS_halted  output  1  FSM is in HALT.
- FS_fault  output  1  memory timeout occurred (tied 0 without the optional feature).
- FS_state  output  3  current state encoding, for debug.
- FS_retired  output  CNT_W  count of retired instructions.

Behaviour:
- State encodings: INIT=0, IDLE=1, FETCH=2, DECODE=3, EXEC_RD=4, EXEC_WR=5, HALT=6. Unused codes go to INIT.
- FS_reset asserted, at any time including mid-transaction:
  - state=INIT immediately.
  - FS_retired=0, FS_fault=0, timeout counter=0.
  - All control outputs 0 while reset is held.
- INIT:
  - FS_pc_reset=1 for exactly one cycle.
  - Next state IDLE unconditionally.
- IDLE:
  - All strobes 0.
  - FS_run=1 -> FETCH, else stay.
- FETCH:
  - FS_pc_output_en=1, FS_mem_read=1.
  - Stay while FS_mem_ready=0.
  - In the cycle FS_mem_ready=1: FS_ir_load=1 and FS_pc_increment=1 (combinational from state and ready), then go to DECODE.
- DECODE:
  - One cycle, no strobes.
  - Opcode 4'h1 LOAD -> EXEC_RD.
  - Opcode 4'h2 STORE -> EXEC_WR.
  - Opcode 4'hF HLT -> HALT.
  - Any other opcode is a NOP: it retires here, then -> FETCH if FS_run=1, else IDLE.
- EXEC_RD:
  - FS_opr_output_en=1, FS_mem_read=1.
  - On FS_mem_ready=1: FS_acc_load=1, retire, then -> FETCH or IDLE per FS_run.
- EXEC_WR:
  - FS_opr_output_en=1, FS_mem_write=1.
  - On FS_mem_ready=1: retire, then -> FETCH or IDLE per FS_run.
- HALT:
  - FS_halted=1, all strobes 0.
  - HLT counts as retired on entry.
  - Leave HALT only via FS_reset.
- Bus exclusivity: FS_pc_output_en and FS_opr_output_en are never both 1. FS_mem_read and FS_mem_write are never both 1.
- FS_run=0 mid-instruction: the current instruction completes, then the FSM goes to IDLE. FS_run is sampled only at retirement and in IDLE.
- FS_retired:
  - Increments by 1 on each retirement.
  - Saturates at 2^CNT_W-1 and does not wrap.
- FS_pc_increment asserts exactly once per FETCH, never during EXEC_* or DECODE.
- Latency: a NOP with zero-wait memory takes 2 cycles (FETCH, DECODE); LOAD and STORE take 3.

Optional Feature:
- Macro: FS_WAIT_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH/EXEC_RD/EXEC_WR and increments each cycle FS_mem_ready=0.
  - When the counter reaches TIMEOUT: go to HALT and set FS_fault=1 (sticky until reset).
  - No strobes in the transition cycle, and the instruction is not retired.
- Not defined:
  - No counter is built; waits are unbounded.
  - FS_fault is tied to 0.

Test Plan:
- Reset -> INIT -> IDLE: after FS_reset falls, FS_pc_reset=1 for exactly 1 cycle, then FS_state=1 and all strobes stay 0 while FS_run=0.
- FS_run=1, FS_mem_ready=1, opcodes NOP,NOP,NOP -> 3 pc_increment pulses spaced 2 cycles apart; FS_retired=3; never both bus enables high.
- LOAD with FS_mem_ready held low 4 cycles in EXEC_RD -> FS_opr_output_en high for 5 cycles, FS_acc_load exactly 1 pulse, FS_pc_increment=0 throughout EXEC_RD.
- STORE then HLT -> one FS_mem_write phase, FS_halted=1, FS_retired=2; FS_run toggling has no effect until FS_reset.
- FS_run dropped during FETCH wait -> instruction completes, FSM enters IDLE; reset asserted mid-EXEC_WR -> FS_mem_write drops asynchronously.
- With FS_WAIT_TIMEOUT_EN and TIMEOUT=8, FS_mem_ready stuck 0 in FETCH -> HALT after 8 wait cycles, FS_fault=1, FS_retired unchanged.
